// File: rtl/queue_arbiter_pkg.sv
// Shared types and defaults for the queue arbiter and its round-robin picker.
package queue_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        FULL_WAIT = 2'd2
    } state_t;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_WIDTH        = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 15;
    localparam int unsigned ACCEPT_COUNT_W   = 16;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/queue_arbiter_rr_picker.sv
// Combinational winner selection: starved requesters first (lowest index),
// otherwise round-robin search upward from the pointer with wrap-around.
module rr_picker
    import queue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned PTR_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] starved,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] urgent;
    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper;

    // Wrap-around search is split into "at or above ptr" then "anywhere";
    // v & -v isolates the lowest set bit of each candidate set.
    always_comb begin
        upper_mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            upper_mask[i] = (i >= 32'(ptr));
        end
        urgent = req & starved;
        upper  = req & upper_mask;
        grant  = '0;
        if (|urgent) begin
            grant = urgent & -urgent;
        end else if (|upper) begin
            grant = upper & -upper;
        end else begin
            grant = req & -req;
        end
    end

endmodule

// File: rtl/queue_arbiter.sv
// Arbitrates NUM_REQ requesters into a single queue write port with
// round-robin fairness and starvation priority.
module queue_arbiter
    import queue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*WIDTH-1:0]  Req_Data,
    output logic [NUM_REQ-1:0]        Grant,
    output logic [WIDTH-1:0]          Q_Data_In,
    output logic                      Q_InputValid,
    input  logic                      Q_IsFull,
    output logic [NUM_REQ-1:0]        Starved,
    output logic                      Busy,
    output logic [ACCEPT_COUNT_W-1:0] Accept_Count
);

    localparam int unsigned PTR_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = idx_width(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] pick;
    logic [CNT_W-1:0]   wait_cnt [NUM_REQ];
    logic [CNT_W-1:0]   wait_next [NUM_REQ];

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (Req),
        .starved (Starved),
        .ptr     (ptr),
        .grant   (pick)
    );

    // Grant only while out of reset and the queue has room; route the winner's word.
    always_comb begin
        Grant     = (Reset && !Q_IsFull) ? pick : '0;
        Q_InputValid = |Grant;
        Q_Data_In = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (Grant[i]) begin
                Q_Data_In = Q_Data_In | Req_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves just past the granted requester; holds otherwise.
    always_comb begin
        ptr_next = ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (Grant[i]) begin
                ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Next state purely from this cycle's request and full inputs.
    always_comb begin
        if (Req == '0) begin
            state_next = IDLE;
        end else if (Q_IsFull) begin
            state_next = FULL_WAIT;
        end else begin
            state_next = ACTIVE;
        end
    end

    // Wait counters count unserved request cycles, saturating; any grant or drop clears.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!Req[i] || Grant[i]) begin
                wait_next[i] = '0;
            end else if (wait_cnt[i] != CNT_MAX) begin
                wait_next[i] = wait_cnt[i] + CNT_W'(1);
            end else begin
                wait_next[i] = wait_cnt[i];
            end
        end
    end

    // Control state, pointer and accepted-word counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            ptr          <= '0;
            Accept_Count <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (Q_InputValid) begin
                Accept_Count <= Accept_Count + ACCEPT_COUNT_W'(1);
            end
        end
    end

    // Starved is registered from the next counter value so it tracks the counter exactly.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            Starved <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= wait_next[i];
                Starved[i]  <= (32'(wait_next[i]) >= STARVE_LIMIT);
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_queue_arbiter.sv
// Scoreboard bench for queue_arbiter: stimulus predicts each cycle's outputs
// from a behavioural model; a negedge monitor pops and compares.
module tb_queue_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LIM = 15;
    localparam int SAT = 15;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [N-1:0]   Req;
    logic [N*W-1:0] Req_Data;
    logic [N-1:0]   Grant;
    logic [W-1:0]   Q_Data_In;
    logic           Q_InputValid;
    logic           Q_IsFull;
    logic [N-1:0]   Starved;
    logic           Busy;
    logic [15:0]    Accept_Count;

    queue_arbiter #(.NUM_REQ(N), .WIDTH(W), .STARVE_LIMIT(LIM)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Req          (Req),
        .Req_Data     (Req_Data),
        .Grant        (Grant),
        .Q_Data_In    (Q_Data_In),
        .Q_InputValid (Q_InputValid),
        .Q_IsFull     (Q_IsFull),
        .Starved      (Starved),
        .Busy         (Busy),
        .Accept_Count (Accept_Count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        valid;
        logic [3:0]  grant;
        logic [31:0] data;
        logic [3:0]  starved;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    // Reference model state (architectural view, not RTL encoding).
    int          m_ptr;
    int          m_wait [N];
    logic        m_busy;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("grant",        32'(Grant),        32'(e.grant));
            check("q_inputvalid", 32'(Q_InputValid), 32'(e.valid));
            check("q_data_in",    Q_Data_In,         e.data);
            check("starved",      32'(Starved),      32'(e.starved));
            check("busy",         32'(Busy),         32'(e.busy));
            check("accept_count", 32'(Accept_Count), 32'(e.cnt));
        end
    end

    task automatic step(input logic r, input logic [3:0] q, input logic f);
        logic [31:0] w [N];
        exp_t e;
        int win;
        @(posedge Clock);
        #1;
        for (int i = 0; i < N; i++) w[i] = $urandom;
        Reset    = r;
        Req      = q;
        Q_IsFull = f;
        Req_Data = {w[3], w[2], w[1], w[0]};
        if (!r) begin
            m_ptr  = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_busy = 1'b0;
            m_cnt  = 16'h0000;
        end
        e.busy = m_busy;
        e.cnt  = m_cnt;
        for (int i = 0; i < N; i++) e.starved[i] = (m_wait[i] >= LIM);
        win = -1;
        if (r && !f) begin
            for (int i = 0; i < N; i++)
                if (win < 0 && q[i] && m_wait[i] >= LIM) win = i;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (win < 0 && q[c]) win = c;
            end
        end
        e.valid = (win >= 0);
        e.grant = (win >= 0) ? 4'(1 << win) : 4'b0000;
        e.data  = (win >= 0) ? w[win] : 32'h0;
        sb.push_back(e);
        if (r) begin
            for (int i = 0; i < N; i++) begin
                if (q[i] && win != i) m_wait[i] = (m_wait[i] + 1 > SAT) ? SAT : m_wait[i] + 1;
                else                  m_wait[i] = 0;
            end
            if (win >= 0) begin
                m_ptr = (win + 1) % N;
                m_cnt = m_cnt + 16'd1;
            end
            m_busy = (q != 4'b0000);
        end
    endtask

    initial begin
        Reset = 1'b0; Req = '0; Q_IsFull = 1'b0; Req_Data = '0;
        m_ptr = 0; m_busy = 1'b0; m_cnt = 16'h0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;

        // Reset state with requests present: nothing granted.
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b0110, 1'b0);

        // All requesting, queue empty: plain rotation.
        for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, 1'b0);

        // Blocked queue builds starvation, then release.
        step(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0101, 1'b1);
        step(1'b1, 4'b0101, 1'b0);
        step(1'b1, 4'b0101, 1'b0);
        step(1'b1, 4'b0000, 1'b0);

        // Pointer at 1, only requester 3 asking: wrap search grants 3.
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);

        // Reset asserted mid-transfer.
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b0000, 1'b0);

        // Random traffic, alternating light and heavy back-pressure epochs.
        for (int t = 0; t < 3000; t++) begin
            logic r, f;
            logic [3:0] q;
            r = ($urandom_range(0, 99) != 0);
            f = ($urandom_range(0, 3) < (((t / 400) % 2 == 1) ? 3 : 1));
            q = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            step(r, q, f);
        end

        // Counter wrap: 65536 transfers from reset bring it back to zero.
        step(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 65536; i++) step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b0000, 1'b0);

        @(negedge Clock);
        #1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge Clock);
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 The block SHALL have parameters: NUM_REQ, default 4, number of requesters; WIDTH, default 32, data word width; STARVE_LIMIT, default 15, wait cycles before starvation.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Req  in  NUM_REQ  per-requester valid; word held stable until granted
- Req_Data  in  NUM_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- Grant  out  NUM_REQ  one-hot accept; word i consumed at this clock edge
- Q_Data_In  out  WIDTH  word to queue Data_In
- Q_InputValid  out  1  to queue InputValid
- Q_IsFull  in  1  from queue IsFull
- Starved  out  NUM_REQ  requester i wait counter >= STARVE_LIMIT
- Busy  out  1  state != IDLE
- Accept_Count  out  16  words written to queue since reset, wraps

Function
REQ-003 Arbitration SHALL be combinational within a cycle: Grant, Q_InputValid and Q_Data_In depend on Req, Q_IsFull, Starved and the RR pointer of the same cycle.
REQ-004 A transfer SHALL occur in a cycle only when |Req = 1 and Q_IsFull = 0; at most one Grant bit SHALL be high per cycle.
REQ-005 Q_InputValid SHALL equal |Grant; Q_Data_In SHALL equal Req_Data slice of the granted requester, else all zeros.
REQ-006 Winner selection: if any requester with Req=1 has Starved=1, the lowest-index such requester SHALL win; otherwise the first requester with Req=1 searching from RR pointer upward, wrapping at NUM_REQ-1 to 0.
REQ-007 On a transfer to requester k, the RR pointer SHALL become (k+1) mod NUM_REQ at the next edge; with no transfer it SHALL hold.
REQ-008 Each requester SHALL have a wait counter: +1 per cycle with Req=1 and Grant=0, saturating at 2^clog2(STARVE_LIMIT+1)-1; cleared when Grant=1 or Req=0.
REQ-009 Starved[i] SHALL be registered, high exactly while wait counter i >= STARVE_LIMIT.
REQ-010 Cycles with Q_IsFull=1 SHALL still increment wait counters of requesters with Req=1.
REQ-011 Accept_Count SHALL increment by 1 on each transfer, wrapping 0xFFFF -> 0x0000.
REQ-012 FSM states IDLE, ACTIVE, FULL_WAIT; next state from current-cycle inputs: Req=0 -> IDLE; Req!=0 and Q_IsFull=0 -> ACTIVE; Req!=0 and Q_IsFull=1 -> FULL_WAIT.
REQ-013 Busy SHALL be high in ACTIVE and FULL_WAIT; state SHALL not gate grants (REQ-004 governs).
REQ-014 A requester deasserting Req without a grant SHALL lose its slot with no side effect except clearing its wait counter.

Reset
REQ-015 Reset low SHALL immediately force: state IDLE, RR pointer 0, all wait counters 0, Starved 0, Accept_Count 0.
REQ-016 While Reset is low, Grant, Q_InputValid SHALL be 0 and Q_Data_In all zeros, regardless of Req.
REQ-017 Reset asserted mid-transfer SHALL abort it; no Grant is issued in that cycle and the word is not counted.

Structure
REQ-018 Package queue_arbiter_pkg SHALL hold the state enum (IDLE, ACTIVE, FULL_WAIT), default NUM_REQ/WIDTH/STARVE_LIMIT and the Accept_Count width constant.
REQ-019 Winner selection SHALL live in combinational sub-module rr_picker (inputs request vector, starved vector, pointer; output one-hot grant).

Verification
REQ-020 After reset, Req=4'b1111, Q_IsFull=0 held 8 cycles -> Grant sequence 0001,0010,0100,1000,0001,...; Accept_Count=8.
REQ-021 Req=4'b0101, Q_IsFull=1 for 20 cycles -> Grant=0, Q_InputValid=0, state FULL_WAIT, Starved=4'b0101 from cycle 16; release full -> Grant=0001 then 0100.
REQ-022 Req=4'b1000 alone with pointer=1 -> Grant=1000 same cycle; Q_Data_In=Req_Data[127:96]; pointer becomes 0.
REQ-023 Accept_Count preloaded to 0xFFFF by 65535 transfers, one more transfer -> 0x0000.
REQ-024 Reset low during a cycle with Req=4'b0010, Q_IsFull=0 -> Grant=0, Q_InputValid=0 immediately; after release pointer=0, counters 0.
